// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: buffer state encoding and
// register-index width helper.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } of_state_e;

  function automatic int idx_width(input int num_regs);
    return (num_regs <= 1) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Upstream instruction and downstream operand handshakes of operand_fetch.
// Valid/ready: a beat moves on a rising edge when valid && ready; a sender
// holds its payload stable while valid && !ready, and ready never depends
// combinationally on valid.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int TAG_W    = 8
);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_src_a;
  logic [IDX_W-1:0] in_src_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_src_a, in_src_b, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_tag
  );

  modport slave (
    input  in_valid, in_src_a, in_src_b, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_tag
  );

endinterface

// File: rtl/operand_fetch_select.sv
// One source operand: register decode with range check and same-edge
// write-back bypass.
module operand_select #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [WIDTH*NUM_REGS-1:0] regs_in,
  input  logic [IDX_W-1:0]          src,
  input  logic                      wb_en,
  input  logic [IDX_W-1:0]          wb_idx,
  input  logic [WIDTH-1:0]          wb_data,
  output logic [WIDTH-1:0]          operand
);

  // An index with no matching register falls through to zero.
  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(src) == i) operand = regs_in[i*WIDTH +: WIDTH];
    end
    if (wb_en && (wb_idx == src)) operand = wb_data;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: selects two bypassed operands per accepted instruction
// and holds them in a main + skid two-entry buffer.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int TAG_W    = 8,
  localparam int IDX_W   = idx_width(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*NUM_REGS-1:0] regs_in,
  input  logic                      wb_en,
  input  logic [IDX_W-1:0]          wb_idx,
  input  logic [WIDTH-1:0]          wb_data,
  operand_fetch_if.slave            bus,
  output of_state_e                 dbg_state
);

  of_state_e        state_q, state_d;
  logic [WIDTH-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic             accept, xfer;

  operand_select #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_sel_a (
    .regs_in(regs_in), .src(bus.in_src_a), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .operand(op_a)
  );

  operand_select #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_sel_b (
    .regs_in(regs_in), .src(bus.in_src_b), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .operand(op_b)
  );

  // Handshake outputs decode only the state register; 2'b11 shows neither.
  assign bus.in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign bus.out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign bus.out_a     = main_a_q;
  assign bus.out_b     = main_b_q;
  assign bus.out_tag   = main_tag_q;
  assign dbg_state     = state_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    main_a_d   = main_a_q;
    main_b_d   = main_b_q;
    main_tag_d = main_tag_q;
    skid_a_d   = skid_a_q;
    skid_b_d   = skid_b_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_ONE;
          main_a_d   = op_a;
          main_b_d   = op_b;
          main_tag_d = bus.in_tag;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          main_a_d   = op_a;
          main_b_d   = op_b;
          main_tag_d = bus.in_tag;
        end else if (accept) begin
          state_d    = ST_FULL;
          skid_a_d   = op_a;
          skid_b_d   = op_b;
          skid_tag_d = bus.in_tag;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d    = ST_ONE;
          main_a_d   = skid_a_q;
          main_b_d   = skid_b_q;
          main_tag_d = skid_tag_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      main_a_q   <= '0;
      main_b_q   <= '0;
      main_tag_q <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      main_a_q   <= main_a_d;
      main_b_q   <= main_b_d;
      main_tag_q <= main_tag_d;
      skid_a_q   <= skid_a_d;
      skid_b_q   <= skid_b_d;
      skid_tag_q <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: streaming vector table plus hand-written
// backpressure, snapshot and asynchronous-reset sequences.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 16;
  localparam int TAG_W    = 8;
  localparam int IDX_W    = 4;

  typedef struct {
    logic [IDX_W-1:0] src_a;
    logic [IDX_W-1:0] src_b;
    logic [TAG_W-1:0] tag;
    logic             wb_en;
    logic [IDX_W-1:0] wb_idx;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [WIDTH*NUM_REGS-1:0] regs_in;
  logic [WIDTH-1:0]          regs [NUM_REGS];
  logic                      wb_en;
  logic [IDX_W-1:0]          wb_idx;
  logic [WIDTH-1:0]          wb_data;
  of_state_e                 dbg_state;

  vec_t             vecs [8];
  logic [TAG_W-1:0] exp_q [$];
  int               n_vec = 0;
  int               n_err = 0;

  operand_fetch_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) bus ();

  operand_fetch #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .regs_in(regs_in), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .bus(bus), .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_in[i*WIDTH +: WIDTH] = regs[i];
  end

  // ---- driver tasks ----
  task automatic drive_in(input logic v, input logic [IDX_W-1:0] a,
                          input logic [IDX_W-1:0] b, input logic [TAG_W-1:0] t);
    bus.in_valid = v;
    bus.in_src_a = a;
    bus.in_src_b = b;
    bus.in_tag   = t;
  endtask

  task automatic drive_wb(input logic en, input logic [IDX_W-1:0] idx,
                          input logic [WIDTH-1:0] d);
    wb_en   = en;
    wb_idx  = idx;
    wb_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- scoreboard ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name);
    logic [TAG_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h expected <empty queue>", name, bus.out_tag);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(bus.out_tag), 32'(e));
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'(i) * 16'h0101;
    regs[2] = 16'h0005;
    regs[3] = 16'h1234;
    regs[5] = 16'hBEEF;
    regs[7] = 16'h0000;

    vecs[0] = '{4'd3,  4'd5,  8'h01, 1'b0, 4'd0,  16'h0000, 16'h1234, 16'hBEEF};
    vecs[1] = '{4'd7,  4'd7,  8'h02, 1'b1, 4'd7,  16'h00FF, 16'h00FF, 16'h00FF};
    vecs[2] = '{4'd7,  4'd3,  8'h03, 1'b1, 4'd3,  16'hAAAA, 16'h0000, 16'hAAAA};
    vecs[3] = '{4'd0,  4'd15, 8'h04, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0F0F};
    vecs[4] = '{4'd15, 4'd15, 8'h05, 1'b1, 4'd15, 16'h5A5A, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{4'd2,  4'd5,  8'h06, 1'b0, 4'd2,  16'h9999, 16'h0005, 16'hBEEF};
    vecs[6] = '{4'd1,  4'd4,  8'h07, 1'b1, 4'd6,  16'hFFFF, 16'h0101, 16'h0404};
    vecs[7] = '{4'd5,  4'd3,  8'hFF, 1'b0, 4'd0,  16'h0000, 16'hBEEF, 16'h1234};

    reset = 1'b0;
    drive_in(1'b0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_a",     32'(bus.out_a),     32'd0);
    check("rst_out_b",     32'(bus.out_b),     32'd0);
    check("rst_out_tag",   32'(bus.out_tag),   32'd0);
    check("rst_state",     32'(dbg_state),     32'(ST_EMPTY));
    @(negedge clk);
    reset = 1'b1;

    // Streaming table: one accept per cycle, each presented right after its edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_in(1'b1, vecs[i].src_a, vecs[i].src_b, vecs[i].tag);
      drive_wb(vecs[i].wb_en, vecs[i].wb_idx, vecs[i].wb_data);
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'd1);
      check($sformatf("vec%0d_out_a", i),     32'(bus.out_a),     32'(vecs[i].exp_a));
      check($sformatf("vec%0d_out_b", i),     32'(bus.out_b),     32'(vecs[i].exp_b));
      check($sformatf("vec%0d_out_tag", i),   32'(bus.out_tag),   32'(vecs[i].tag));
    end
    @(negedge clk);
    drive_in(1'b0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_in_ready",  32'(bus.in_ready),  32'd1);

    // Backpressure: two accepts fill main + skid, a third offer must be refused.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_in(1'b1, 4'd3, 4'd5, 8'h10);
    exp_q.push_back(8'h10);
    tick();
    check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp1_out_tag",  32'(bus.out_tag),  32'h10);
    @(negedge clk);
    drive_in(1'b1, 4'd5, 4'd3, 8'h11);
    exp_q.push_back(8'h11);
    tick();
    check("bp2_in_ready",  32'(bus.in_ready),  32'd0);
    check("bp2_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp2_out_tag",   32'(bus.out_tag),   32'h10);
    check("bp2_state",     32'(dbg_state),     32'(ST_FULL));
    @(negedge clk);
    drive_in(1'b1, 4'd1, 4'd1, 8'h12);
    tick();
    check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp3_out_tag",  32'(bus.out_tag),  32'h10);
    check("bp3_out_a",    32'(bus.out_a),    32'h1234);
    @(negedge clk);
    drive_in(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    check_pop("bp_first_tag");
    tick();
    check_pop("bp_second_tag");
    check("bp4_out_a",    32'(bus.out_a),    32'hBEEF);
    check("bp4_out_b",    32'(bus.out_b),    32'h1234);
    check("bp4_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp5_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Snapshot: a later write to r2 must not reach the buffered entry.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_in(1'b1, 4'd2, 4'd2, 8'h20);
    tick();
    check("snap1_out_a", 32'(bus.out_a), 32'h0005);
    @(negedge clk);
    drive_in(1'b0, '0, '0, '0);
    drive_wb(1'b1, 4'd2, 16'h0009);
    tick();
    regs[2] = 16'h0009;
    drive_wb(1'b0, '0, '0);
    tick();
    check("snap2_out_a",   32'(bus.out_a),   32'h0005);
    check("snap2_out_b",   32'(bus.out_b),   32'h0005);
    check("snap2_out_tag", 32'(bus.out_tag), 32'h20);

    // Reset while FULL, asserted between clock edges.
    @(negedge clk);
    drive_in(1'b1, 4'd3, 4'd3, 8'h21);
    tick();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_out_tag",   32'(bus.out_tag),   32'd0);
    check("arst_out_a",     32'(bus.out_a),     32'd0);
    drive_in(1'b0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("post_rst_out_valid2", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    drive_in(1'b1, 4'd2, 4'd5, 8'h30);
    tick();
    check("post_rst_tag",   32'(bus.out_tag), 32'h30);
    check("post_rst_out_a", 32'(bus.out_a),   32'h0009);
    @(negedge clk);
    drive_in(1'b0, '0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch stage directly downstream of `register_file`. Consumes the flattened `data_out` register bus and, for each accepted instruction, selects two source operands with write-back bypass. Registers the operands, with a tag, into a two-entry skid buffer. Valid/ready handshakes on both sides; full throughput of one instruction per cycle under no backpressure.

## Interface
Parameters:
- `WIDTH`, 16, register width in bits (matches `register_file` WIDTH)
- `NUM_REGS`, 16, number of registers (matches `register_file` NUM_REGS)
- `TAG_W`, 8, width of opaque instruction tag passed through unchanged
- `IDX_W` (localparam), `$clog2(NUM_REGS)`, register index width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low
- `regs_in`  in  WIDTH*NUM_REGS  flattened register contents; register i at `[i*WIDTH +: WIDTH]`
- `wb_en`  in  1  a register-file write commits at this clock edge
- `wb_idx`  in  IDX_W  index being written
- `wb_data`  in  WIDTH  value being written
- `in_valid`  in  1  upstream instruction present
- `in_ready`  out  1  stage can accept
- `in_src_a`, `in_src_b`  in  IDX_W  source register indices
- `in_tag`  in  TAG_W  opaque tag
- `out_valid`  out  1  operands present
- `out_ready`  in  1  downstream consumes
- `out_a`, `out_b`  out  WIDTH  operand values
- `out_tag`  out  TAG_W  tag of the presented operands

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`; transfer occurs on a rising edge with `out_valid && out_ready`.
- Operand select, per source: if `wb_en && wb_idx == src`, use `wb_data` (bypass). Else, if `src < NUM_REGS`, use `regs_in[src]`. Else use 0.
- Operands are a snapshot at accept time. Writes after accept never update a buffered entry.
- Storage is a main register (drives `out_*`) plus a skid register.
- States are encoded in `state[1:0]`:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - ONE: main valid, `out_valid=1`, `in_ready=1`.
  - FULL: main and skid valid, `out_valid=1`, `in_ready=0`.
- Transitions:
  - EMPTY + accept -> ONE (load main).
  - ONE + accept, no transfer -> FULL (load skid).
  - ONE + transfer, no accept -> EMPTY.
  - ONE + accept + transfer -> ONE (load main with new entry).
  - FULL + transfer -> ONE (skid moves to main).
  - Otherwise the state holds.
- `in_ready` and `out_valid` are decoded from state only. They have no combinational path from `in_valid` or `out_ready`.
- `out_a`, `out_b` and `out_tag` are held stable while `out_valid && !out_ready`.
- The encoding value 2'b11 is illegal and recovers to EMPTY.

## Timing
- Reset low: state EMPTY, `out_valid=0`, `in_ready=1`, `out_a=out_b=0`, `out_tag=0`, skid cleared.
- Reset asserted mid-operation discards all buffered entries at once. It is asynchronous and does not wait for a clock edge.
- Latency: an instruction accepted at edge k is presented on `out_*` from just after edge k.
- Throughput: one per cycle while `out_ready=1`.
- Backpressure: `in_ready` falls the cycle after the second unconsumed accept. At most 2 entries are in flight.
- Bypass applies only to the `wb_*` write committing at the same edge as the accept. Earlier writes are already visible in `regs_in`.
- Both sources may hit the bypass at once, including `src_a == src_b == wb_idx`.

## Structure
- Shared package `operand_fetch_pkg`: state encodings EMPTY/ONE/FULL, and a `clog2`-based index-width function.
- Sub-module `operand_select`: combinational index decode, range check and bypass mux. It is instantiated twice, once for a and once for b.
- The top level holds the state machine and the main and skid registers.

## Test plan
- Reset, then r3=0x1234 and r5=0xBEEF in `regs_in`; accept src_a=3, src_b=5, tag=0x01 with `out_ready=1` -> next cycle `out_valid=1`, `out_a=0x1234`, `out_b=0xBEEF`, `out_tag=0x01`.
- Bypass: r7=0x0000, `wb_en=1`, `wb_idx=7`, `wb_data=0x00FF` at the accept edge; src_a=src_b=7 -> `out_a=out_b=0x00FF`.
- Backpressure: `out_ready=0`, accept tags 0x10 then 0x11 -> `in_ready=0`, `out_tag=0x10` held. Raise `out_ready` -> tags 0x10, 0x11 emerge in order, then `in_ready=1`.
- Streaming: 8 back-to-back accepts with `out_ready=1` -> 8 transfers on consecutive cycles, tags in order, `in_ready` never low.
- Snapshot: accept src_a=2 (r2=0x0005) with `out_ready=0`; write r2=0x0009 next cycle -> `out_a` stays 0x0005.
- Reset in FULL: drop `reset` low between clock edges -> `out_valid=0` and `in_ready=1` immediately; no stale tag appears after release.
